// File: rtl/riscv_defs_pkg.sv
// Shared RV32I pipeline definitions: reset/NOP constants and fetch FSM encodings.
// Used by instruction_fetch_unit and ifu_fetch_buffer.
package riscv_defs_pkg;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_buffer.sv
// One-entry {instr, pc, valid} holding register between instruction memory and IF/ID.
// Priority: clear > load > consume; an empty entry always shows the NOP word.
module ifu_fetch_buffer
  import riscv_defs_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic        consume,
  input  logic        clear,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (consume) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I IF stage: owns the PC, fetches over a req/ack handshake, handles stall and redirect.
// Optional IFU_MISALIGN_CHECK_EN adds a registered misaligned_out pulse for unaligned redirects.
module instruction_fetch_unit
  import riscv_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        misaligned_out
`endif
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  drop_addr_reg;
  logic         pending_reg;
  logic         in_fetch;
  logic         load;
  logic         consume;

  assign in_fetch = (state_reg == ST_FETCH);
  assign load     = in_fetch && imem_req && imem_ack && !redirect_valid;
  assign consume  = valid_out && !stall_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_BOOT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: if (redirect_valid && imem_req && !imem_ack) state_next = ST_DROP;
      ST_DROP:  if (imem_ack) state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase
  end

  // An outstanding request keeps req high even if the buffer fills and IF/ID stalls.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state_reg)
      ST_FETCH: imem_req = pending_reg || !valid_out || !stall_in;
      ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) pc_next = align_word(redirect_pc);
    else if (load)      pc_next = pc_reg + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg        <= RESET_PC;
      drop_addr_reg <= RESET_PC;
      pending_reg   <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      pending_reg <= in_fetch && imem_req && !imem_ack && !redirect_valid;
      // Remember the address in flight so DROP can keep presenting it after pc moves on.
      if (in_fetch && redirect_valid) drop_addr_reg <= pc_reg;
    end
  end

  ifu_fetch_buffer #(
    .NOP_WORD (NOP_INSTR)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_instr (imem_rdata),
    .load_pc    (pc_reg),
    .consume    (consume),
    .clear      (redirect_valid),
    .instr      (instruction_out),
    .pc         (pc_out),
    .valid      (valid_out)
  );

`ifdef IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misaligned_out <= 1'b0;
    else        misaligned_out <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with a variable-latency memory model.
// Define IFU_MISALIGN_CHECK_EN to also check misaligned_out.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misaligned_out;
`endif

  int     compared = 0;
  int     mismatched = 0;
  entry_t exp_q[$];
  bit     mon_en = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .misaligned_out  (misaligned_out)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the queue mirrors what the IF/ID-facing buffer must hold right now.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_out", valid_out, exp_q.size() != 0);
      if (exp_q.size() == 0) begin
        check("idle_nop", instruction_out, NOP);
      end else begin
        check("instr", instruction_out, exp_q[0].instr);
        check("pc_out", pc_out, exp_q[0].pc);
        if (!stall_in && !redirect_valid) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit          mem_busy;
    bit          mem_discard;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    bit          c_push;
    bit          c_redir;
    entry_t      c_entry;
`ifdef IFU_MISALIGN_CHECK_EN
    bit          c_mis;
    c_mis = 1'b0;
`endif
    mem_busy = 1'b0;
    mem_discard = 1'b0;
    mem_wait = 0;
    mem_addr = '0;
    exp_pc = 32'h0000_0000;
    c_push = 1'b0;
    c_redir = 1'b0;
    c_entry = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_valid", valid_out, 0);
      check("rst_req", imem_req, 0);
      check("rst_instr", instruction_out, NOP);
      check("rst_pc_out", pc_out, 0);
    end
    reset = 1'b1;
    #1;
    check("boot_no_req", imem_req, 0);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (c_redir) exp_q.delete();
      else if (c_push) exp_q.push_back(c_entry);
`ifdef IFU_MISALIGN_CHECK_EN
      check("misaligned_out", misaligned_out, c_mis);
      c_mis = 1'b0;
`endif
      c_push = 1'b0;
      c_redir = 1'b0;

      stall_in = ($urandom_range(0, 99) < 30);
      redirect_valid = (cyc > 0) && ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                 : $urandom;
      imem_ack = 1'b0;
      #1;
      if (cyc == 0) check("first_req", imem_req, 1);

      if (mem_busy) begin
        check("req_held", imem_req, 1);
        check("addr_stable", imem_addr, mem_addr);
      end else begin
        check("req_rule", imem_req, !((exp_q.size() != 0) && stall_in));
        if (imem_req) begin
          check("req_addr", imem_addr, exp_pc);
          mem_busy = 1'b1;
          mem_addr = exp_pc;
          mem_wait = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
        end
      end

      imem_ack = mem_busy && (mem_wait == 0);
      imem_rdata = imem_ack ? mem_word(mem_addr) : $urandom;
      if (mem_busy && mem_wait > 0) mem_wait--;

      if (redirect_valid) begin
        c_redir = 1'b1;
        exp_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHECK_EN
        c_mis = (redirect_pc[1:0] != 2'b00);
`endif
        if (mem_busy && !imem_ack) mem_discard = 1'b1;
      end else if (imem_ack && !mem_discard) begin
        c_push = 1'b1;
        c_entry.instr = mem_word(mem_addr);
        c_entry.pc = mem_addr;
        exp_pc = mem_addr + 32'd4;
      end
      if (imem_ack) begin
        mem_busy = 1'b0;
        mem_discard = 1'b0;
      end
      #1;
    end

    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midrun_rst_req", imem_req, 0);
    check("midrun_rst_valid", valid_out, 0);
    check("midrun_rst_instr", instruction_out, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
